// File: rtl/regdump_streamer.sv
// Register-file snapshot engine for debug builds.
// A trigger captures the whole register file into a shadow buffer. The engine
// then streams (index, data) beats over a valid/ready interface, either for
// every register or only for those that changed since the previous frame.
// Every output is driven straight from a flop.
module regdump_streamer #(
    parameter int RLEN = 32,
    parameter int XLEN = 32,
    parameter int FCW  = 16
) (
    input  logic                     XCLK,
    input  logic                     XRES,
    input  logic [RLEN*XLEN-1:0]     REGS_FLAT,
    input  logic                     TRIG,
    input  logic                     MODE_DELTA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [$clog2(RLEN)-1:0]  OUT_IDX,
    output logic [XLEN-1:0]          OUT_DATA,
    output logic                     OUT_LAST,
    output logic                     BUSY,
    output logic                     FRAME_DONE,
    output logic [FCW-1:0]           FRAME_CNT,
    output logic [FCW-1:0]           DROP_CNT
);

    localparam int IW = $clog2(RLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [XLEN-1:0]     shadow_r [RLEN];
    logic [XLEN-1:0]     prev_r   [RLEN];
    logic                prev_valid_r;
    logic [RLEN-1:0]     mask_r;

    logic [XLEN-1:0]     live_s   [RLEN];
    logic [RLEN-1:0]     cap_mask_s;
    logic [RLEN-1:0]     rem_mask_s;
    logic [IW-1:0]       cap_lo_s;
    logic [IW-1:0]       cap_hi_s;
    logic [IW-1:0]       rem_lo_s;
    logic [IW-1:0]       rem_hi_s;
    logic                hs_s;

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [IW-1:0] lowest_set(input logic [RLEN-1:0] m);
        logic [IW-1:0] r;
        r = {IW{1'b0}};
        for (int i = RLEN - 1; i >= 0; i--) begin
            r = m[i] ? IW'(i) : r;
        end
        return r;
    endfunction

    // Index of the highest set bit (0 when the mask is empty).
    function automatic logic [IW-1:0] highest_set(input logic [RLEN-1:0] m);
        logic [IW-1:0] r;
        r = {IW{1'b0}};
        for (int i = 0; i < RLEN; i++) begin
            r = m[i] ? IW'(i) : r;
        end
        return r;
    endfunction

    // Unpack the live file, build the capture mask and the post-handshake mask.
    always_comb begin
        for (int i = 0; i < RLEN; i++) begin
            live_s[i]     = REGS_FLAT[i*XLEN +: XLEN];
            cap_mask_s[i] = !MODE_DELTA || !prev_valid_r ||
                            (REGS_FLAT[i*XLEN +: XLEN] != prev_r[i]);
            rem_mask_s[i] = mask_r[i] && (OUT_IDX != IW'(i));
        end
    end

    assign cap_lo_s = lowest_set(cap_mask_s);
    assign cap_hi_s = highest_set(cap_mask_s);
    assign rem_lo_s = lowest_set(rem_mask_s);
    assign rem_hi_s = highest_set(rem_mask_s);
    assign hs_s     = OUT_VALID && OUT_READY;

    // Frame sequencer: capture, stream beats, close frame, count drops.
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state_r      <= ST_IDLE;
            prev_valid_r <= 1'b0;
            mask_r       <= {RLEN{1'b0}};
            for (int i = 0; i < RLEN; i++) begin
                shadow_r[i] <= {XLEN{1'b0}};
                prev_r[i]   <= {XLEN{1'b0}};
            end
            OUT_VALID    <= 1'b0;
            OUT_IDX      <= {IW{1'b0}};
            OUT_DATA     <= {XLEN{1'b0}};
            OUT_LAST     <= 1'b0;
            BUSY         <= 1'b0;
            FRAME_DONE   <= 1'b0;
            FRAME_CNT    <= {FCW{1'b0}};
            DROP_CNT     <= {FCW{1'b0}};
        end else begin
            // Any trigger seen while a frame is in progress is dropped.
            if (BUSY && TRIG && (DROP_CNT != {FCW{1'b1}})) begin
                DROP_CNT <= DROP_CNT + FCW'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (TRIG) begin
                        for (int i = 0; i < RLEN; i++) begin
                            shadow_r[i] <= live_s[i];
                        end
                        mask_r <= cap_mask_s;
                        BUSY   <= 1'b1;
                        if (cap_mask_s != {RLEN{1'b0}}) begin
                            state_r   <= ST_SEND;
                            OUT_VALID <= 1'b1;
                            OUT_IDX   <= cap_lo_s;
                            OUT_DATA  <= live_s[cap_lo_s];
                            OUT_LAST  <= (cap_lo_s == cap_hi_s);
                        end else begin
                            // Empty delta frame: straight to the close-out cycle.
                            state_r    <= ST_DONE;
                            FRAME_DONE <= 1'b1;
                            FRAME_CNT  <= FRAME_CNT + FCW'(1);
                        end
                    end
                end
                ST_SEND: begin
                    if (hs_s) begin
                        mask_r <= rem_mask_s;
                        if (OUT_LAST) begin
                            state_r    <= ST_DONE;
                            OUT_VALID  <= 1'b0;
                            OUT_IDX    <= {IW{1'b0}};
                            OUT_DATA   <= {XLEN{1'b0}};
                            OUT_LAST   <= 1'b0;
                            FRAME_DONE <= 1'b1;
                            FRAME_CNT  <= FRAME_CNT + FCW'(1);
                        end else begin
                            OUT_IDX  <= rem_lo_s;
                            OUT_DATA <= shadow_r[rem_lo_s];
                            OUT_LAST <= (rem_lo_s == rem_hi_s);
                        end
                    end
                end
                ST_DONE: begin
                    // The captured frame becomes the reference for the next delta.
                    for (int i = 0; i < RLEN; i++) begin
                        prev_r[i] <= shadow_r[i];
                    end
                    prev_valid_r <= 1'b1;
                    FRAME_DONE   <= 1'b0;
                    BUSY         <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regdump_streamer.sv
// Directed bench for regdump_streamer: a table of frames (mode, register edits,
// READY pattern, expected beat count / first / last index / completion cycle)
// applied by one frame runner, plus hand-written reset sequences.
module tb_regdump_streamer;

    localparam int RLEN = 32;
    localparam int XLEN = 32;
    localparam int FCW  = 16;
    localparam int IW   = 5;

    logic                 XCLK = 1'b0;
    logic                 XRES = 1'b0;
    logic [RLEN*XLEN-1:0] REGS_FLAT;
    logic                 TRIG = 1'b0;
    logic                 MODE_DELTA = 1'b0;
    logic                 OUT_VALID;
    logic                 OUT_READY = 1'b0;
    logic [IW-1:0]        OUT_IDX;
    logic [XLEN-1:0]      OUT_DATA;
    logic                 OUT_LAST;
    logic                 BUSY;
    logic                 FRAME_DONE;
    logic [FCW-1:0]       FRAME_CNT;
    logic [FCW-1:0]       DROP_CNT;

    regdump_streamer #(.RLEN(RLEN), .XLEN(XLEN), .FCW(FCW)) dut (
        .XCLK(XCLK), .XRES(XRES), .REGS_FLAT(REGS_FLAT), .TRIG(TRIG),
        .MODE_DELTA(MODE_DELTA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_IDX(OUT_IDX), .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .FRAME_CNT(FRAME_CNT),
        .DROP_CNT(DROP_CNT)
    );

    always #5 XCLK = ~XCLK;

    // Live register file driven into the DUT, and the bench's reference snapshot.
    logic [XLEN-1:0] lv   [RLEN];
    logic [XLEN-1:0] snap [RLEN];
    logic            m_prev_valid;
    int              m_frames;
    int              m_drops;

    always_comb begin
        for (int i = 0; i < RLEN; i++) REGS_FLAT[i*XLEN +: XLEN] = lv[i];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge XCLK);
        #1;
    endtask

    typedef struct {
        logic        mode;
        int          chg_a;
        logic [31:0] val_a;
        int          chg_b;
        logic [31:0] val_b;
        logic [3:0]  rdy_pat;
        int          exp_beats;
        int          exp_first;
        int          exp_last;
        int          exp_done;
        logic        drop_test;
    } frame_vec_t;

    frame_vec_t vecs [8];

    task automatic check_all_zero(input string tag);
        chk({tag, " valid"},  OUT_VALID,  1'b0);
        chk({tag, " idx"},    OUT_IDX,    5'd0);
        chk({tag, " data"},   OUT_DATA,   32'd0);
        chk({tag, " last"},   OUT_LAST,   1'b0);
        chk({tag, " busy"},   BUSY,       1'b0);
        chk({tag, " done"},   FRAME_DONE, 1'b0);
        chk({tag, " fcnt"},   FRAME_CNT,  16'd0);
        chk({tag, " dcnt"},   DROP_CNT,   16'd0);
    endtask

    task automatic run_frame(input frame_vec_t v, input string tag);
        int              q[$];
        int              beats, first, lastb, done_c;
        logic            held;
        logic [IW-1:0]   h_idx;
        logic [XLEN-1:0] h_data;
        logic            h_last;
        logic [XLEN-1:0] cap [RLEN];
        if (v.chg_a >= 0) lv[v.chg_a] = v.val_a;
        if (v.chg_b >= 0) lv[v.chg_b] = v.val_b;
        #1;
        for (int i = 0; i < RLEN; i++) begin
            cap[i] = lv[i];
            if (!v.mode || !m_prev_valid || lv[i] != snap[i]) q.push_back(i);
        end
        MODE_DELTA = v.mode;
        TRIG = 1'b1;
        tick;
        TRIG = 1'b0;
        MODE_DELTA = 1'b0;
        beats = 0; first = -1; lastb = -1; done_c = -1;
        held = 1'b0; h_idx = '0; h_data = '0; h_last = 1'b0;
        for (int c = 0; c < 200; c++) begin
            OUT_READY = v.rdy_pat[c % 4];
            if (v.drop_test) begin
                TRIG = (c == 5 || c == 20 || c == 31);
                if (c == 3) lv[10] = 32'hCAFEF00D;
            end
            if (c == 0) chk({tag, " first-valid"}, OUT_VALID, (q.size() > 0));
            if (held) begin
                chk({tag, " hold-valid"}, OUT_VALID, 1'b1);
                chk({tag, " hold-idx"},   OUT_IDX,   h_idx);
                chk({tag, " hold-data"},  OUT_DATA,  h_data);
                chk({tag, " hold-last"},  OUT_LAST,  h_last);
            end
            if (FRAME_DONE) begin
                done_c = c;
                break;
            end
            if (OUT_VALID && OUT_READY) begin
                if (beats < q.size()) chk({tag, " beat-idx"}, OUT_IDX, q[beats]);
                else chk({tag, " extra-beat"}, beats, q.size());
                chk({tag, " beat-data"}, OUT_DATA, cap[OUT_IDX]);
                chk({tag, " beat-last"}, OUT_LAST, (beats == q.size() - 1));
                if (first < 0) first = int'(OUT_IDX);
                lastb = int'(OUT_IDX);
                beats++;
            end
            held = OUT_VALID && !OUT_READY;
            h_idx = OUT_IDX; h_data = OUT_DATA; h_last = OUT_LAST;
            tick;
        end
        TRIG = 1'b0;
        chk({tag, " done-cycle"}, done_c, v.exp_done);
        chk({tag, " beats"},      beats,  v.exp_beats);
        chk({tag, " first-idx"},  first,  v.exp_first);
        chk({tag, " last-idx"},   lastb,  v.exp_last);
        m_frames++;
        if (v.drop_test) m_drops += 3;
        chk({tag, " frame-cnt"},  FRAME_CNT, m_frames[15:0]);
        chk({tag, " drop-cnt"},   DROP_CNT,  m_drops[15:0]);
        chk({tag, " busy-done"},  BUSY,      1'b1);
        chk({tag, " valid-done"}, OUT_VALID, 1'b0);
        tick;
        chk({tag, " done-pulse"}, FRAME_DONE, 1'b0);
        chk({tag, " busy-idle"},  BUSY,       1'b0);
        for (int i = 0; i < RLEN; i++) snap[i] = cap[i];
        m_prev_valid = 1'b1;
        if (v.drop_test) lv[10] = cap[10];
        OUT_READY = 1'b0;
    endtask

    initial begin
        //          mode  chgA val_a         chgB val_b         rdy      beats first last done drop
        vecs[0] = '{1'b0, -1,  32'h0,        -1,  32'h0,        4'b1111, 32,   0,    31,  32,  1'b0};
        vecs[1] = '{1'b0, -1,  32'h0,        -1,  32'h0,        4'b1001, 32,   0,    31,  64,  1'b0};
        vecs[2] = '{1'b1,  5,  32'hDEADBEEF, 17,  32'h12345678, 4'b1111, 2,    5,    17,  2,   1'b0};
        vecs[3] = '{1'b1, -1,  32'h0,        -1,  32'h0,        4'b1111, 0,    -1,   -1,  0,   1'b0};
        vecs[4] = '{1'b1,  0,  32'hA5A5A5A5, 31,  32'h5A5A5A5A, 4'b0101, 2,    0,    31,  3,   1'b0};
        vecs[5] = '{1'b0, -1,  32'h0,        -1,  32'h0,        4'b1111, 32,   0,    31,  32,  1'b1};
        vecs[6] = '{1'b1, -1,  32'h0,        -1,  32'h0,        4'b1111, 0,    -1,   -1,  0,   1'b0};
        vecs[7] = '{1'b1, -1,  32'h0,        -1,  32'h0,        4'b1111, 32,   0,    31,  32,  1'b0};

        for (int i = 0; i < RLEN; i++) begin
            lv[i]   = 32'(i * 32'h11111111);
            snap[i] = 32'h0;
        end
        m_prev_valid = 1'b0;
        m_frames = 0;
        m_drops  = 0;

        // Power-on reset state.
        tick;
        tick;
        check_all_zero("reset");
        XRES = 1'b1;
        tick;
        check_all_zero("post-reset");

        for (int k = 0; k < 7; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

        // Reset in the middle of a full frame, at beat 10.
        OUT_READY = 1'b1;
        TRIG = 1'b1;
        tick;
        TRIG = 1'b0;
        repeat (10) tick;
        chk("midreset beat10-idx", OUT_IDX, 5'd10);
        chk("midreset beat10-valid", OUT_VALID, 1'b1);
        #2;
        XRES = 1'b0;
        #1;
        check_all_zero("midreset");
        tick;
        check_all_zero("midreset-held");
        XRES = 1'b1;
        OUT_READY = 1'b0;
        m_frames = 0;
        m_drops  = 0;
        m_prev_valid = 1'b0;
        tick;
        check_all_zero("after-release");

        // First delta after reset behaves as a first frame: all registers.
        run_frame(vecs[7], "vec7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/regdump_streamer.md
Name: regdump_streamer

Overview:
- Synthesizable register-file snapshot engine for darksocv debug builds.
- On a trigger it captures the whole core register file into a shadow buffer. It then streams the captured entries out as (index, data) beats over a valid/ready interface.
- Two dump modes:
  - Full: every register.
  - Delta: only registers changed since the previous dumped frame.
- Sits beside core0. Feeds the UART/trace path, replacing the simulation-only register dump loop.

Parameters:
- RLEN, 32, number of architectural registers captured (16 for RV32E builds); power of two, ≥2.
- XLEN, 32, register width in bits.
- FCW, 16, width of the frame and drop counters.

Ports:
- XCLK  in  1  system clock.
- XRES  in  1  asynchronous reset, active-low.
- REGS_FLAT  in  RLEN*XLEN  live register file; register i at bits [i*XLEN +: XLEN].
- TRIG  in  1  snapshot request, sampled on rising XCLK.
- MODE_DELTA  in  1  0 = full dump, 1 = delta dump; latched with TRIG.
- OUT_VALID  out  1  beat valid.
- OUT_READY  in  1  sink ready.
- OUT_IDX  out  $clog2(RLEN)  register index of the beat.
- OUT_DATA  out  XLEN  captured register value.
- OUT_LAST  out  1  final beat of the frame.
- BUSY  out  1  frame in progress; high from the cycle after an accepted TRIG until the cycle after FRAME_DONE.
- FRAME_DONE  out  1  one-cycle pulse when a frame completes.
- FRAME_CNT  out  FCW  completed frames, wraps modulo 2^FCW.
- DROP_CNT  out  FCW  triggers ignored while BUSY; saturates at all-ones.

Behaviour:
- Reset (XRES=0, asynchronous) forces:
  - All outputs to 0.
  - State to IDLE.
  - Shadow and previous-snapshot buffers cleared.
  - PREV_VALID = 0.
- Reset mid-frame aborts the frame immediately; the next delta frame behaves as a first frame.
- FSM states are IDLE, SEND, DONE.
- IDLE:
  - TRIG=1 at an edge copies REGS_FLAT into the shadow buffer and latches MODE_DELTA.
  - Mask: full mode, or PREV_VALID=0, selects all RLEN entries. Otherwise a bit is set only where shadow ≠ previous snapshot.
  - If the mask is non-zero, go to SEND; otherwise go to DONE.
- SEND:
  - The pointer is the lowest set mask bit at or above the current index.
  - OUT_VALID rises the cycle after the trigger edge (latency 1).
  - On VALID&READY, clear that mask bit. The next set index is presented the following cycle with no bubble.
  - OUT_LAST=1 exactly when the presented index is the highest set mask bit.
  - The handshake on the LAST beat moves to DONE.
  - OUT_IDX, OUT_DATA and OUT_LAST hold stable while VALID=1 and READY=0.
  - VALID never drops without a handshake.
- DONE (one cycle):
  - FRAME_DONE=1, FRAME_CNT+1.
  - Previous snapshot ← shadow; PREV_VALID=1.
  - Return to IDLE.
  - An empty delta frame still passes through DONE: zero beats, counter increments, BUSY high for exactly one cycle.
- TRIG while BUSY is ignored and DROP_CNT increments. This includes a trigger in the same cycle as the final handshake or in DONE.
- TRIG held high re-triggers on the first IDLE cycle after DONE.
- REGS_FLAT changes after the capture edge never affect the frame in flight.
- Index 0 is treated like any other entry; no special-casing of x0.
- Mode change between frames:
  - A full frame still updates the previous snapshot.
  - A following delta frame compares against that full frame.

Test Plan:
- Full dump, READY tied 1, RLEN=32, REGS[i]=i*0x11111111 (low 32 bits) → TRIG at cycle 0; beats idx 0..31 on cycles 1..32 with matching data; OUT_LAST only on idx 31; FRAME_DONE at cycle 33; FRAME_CNT=1.
- Backpressure: READY toggles 1,0,0,1,… during a full dump → each beat held stable while READY=0; no index skipped or repeated; 32 beats total.
- Delta: after a full frame, change only REGS[5]=0xDEADBEEF and REGS[17]=0x12345678, TRIG with MODE_DELTA=1 → exactly two beats: (5,0xDEADBEEF), then (17,0x12345678) with LAST=1.
- Delta with no change → zero beats; FRAME_DONE one cycle after TRIG; FRAME_CNT increments; BUSY high one cycle.
- TRIG pulses during a frame, including the LAST-handshake cycle (3 pulses) → DROP_CNT=3, the frame is unaffected, and REGS_FLAT changes after capture do not appear in the output.
- XRES low mid-frame at beat 10, then release and delta TRIG → outputs 0 during reset; the post-reset delta frame emits all 32 registers.
